// File: rtl/is_uart_tx_fsm.sv
// rtl/is_uart_tx_fsm.sv - UART transmit serializer driven by the TX sample counter bit strobe.
module is_uart_tx_fsm #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   input  logic              tx_ce_i,
   output logic              txct_r_o,
   output logic              tx_o,
   output logic              tx_busy_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                stop_cnt_q, stop_cnt_d;
   logic                parity_q, parity_d;
   logic                tx_q, tx_d;
   logic                accept;

   assign tx_ready_o = (state_q == S_IDLE);
   assign tx_busy_o  = (state_q != S_IDLE);
   assign accept     = tx_ready_o && tx_valid_i;
   // Counter restart coincides with the accept edge so the start bit gets a full period.
   assign txct_r_o   = accept;
   assign tx_o       = tx_q;

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      parity_d   = parity_q;
      tx_d       = tx_q;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (accept) begin
               shift_d    = tx_data_i;
               parity_d   = (^tx_data_i) ^ (PARITY_ODD != 0);
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
               tx_d       = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (tx_ce_i) begin
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_ce_i) begin
               shift_d   = shift_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  stop_cnt_d = 1'b0;
                  if (PARITY_EN != 0) begin
                     tx_d    = parity_q;
                     state_d = S_PARITY;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = S_STOP;
                  end
               end else begin
                  tx_d = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            tx_d = parity_q;
            if (tx_ce_i) begin
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (tx_ce_i) begin
               if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
               end else begin
                  stop_cnt_d = stop_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         parity_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         parity_q   <= parity_d;
         tx_q       <= tx_d;
      end
   end

endmodule
